tx_seq_ctrl: RTL and testbench
==============================

# tx_seq_ctrl

Burst sequencer for the PRBS9 → tx_mod transmit chain. It produces the per-symbol advance strobe for `prbs9_mod`, the sample-rate enable for `tx_mod`, and a symbol-gating flag. It also counts symbols for a programmed burst length and drains the shaping filter with zero symbols before returning to idle. It sits between the top-level start/stop control and the two datapath blocks.

## Interface
Parameters:
- `OS`, 4, oversampling factor: clock cycles per symbol (≥2).
- `NSYM_W`, 16, width of the burst-length field.
- `DRAIN_SYM`, 6, zero symbols fed after the last data symbol (≥1; covers the filter span).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  single-cycle burst start request.
- `i_stop`  in  1  single-cycle stop request.
- `i_nsym`  in  NSYM_W  burst length in symbols, sampled with `i_start`. 0 = continuous until stop.
- `o_prbs_en`  out  1  advance strobe to `prbs9_mod.enable`, one cycle per symbol.
- `o_tx_en`  out  1  enable to `tx_mod.enable`.
- `o_sym_valid`  out  1  1 = pass the PRBS bit to `tx_mod.symbol`, 0 = force symbol 0.
- `o_phase`  out  $clog2(OS)  sample phase within the current symbol.
- `o_busy`  out  1  high in RUN and DRAIN.
- `o_done`  out  1  one-cycle pulse when a burst fully drains.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset places the FSM in IDLE and clears the phase counter, symbol counter, drain counter and stop_pending.
- The FSM has three states: IDLE, RUN and DRAIN.
- IDLE:
  - All enables are 0.
  - `i_start`=1 with `i_stop`=0: latch `i_nsym`, clear the counters, go to RUN.
  - `i_start` and `i_stop` both 1: stay in IDLE.
  - `i_stop` alone: ignored.
- RUN:
  - `o_tx_en`=1 and `o_sym_valid`=1.
  - `o_phase` counts 0…OS-1 and wraps.
  - `o_prbs_en`=1 only when `o_phase`=OS-1.
  - The symbol counter increments on each `o_prbs_en` cycle.
- RUN exit conditions:
  - Latched nsym≠0: leave RUN after the cycle where `o_phase`=OS-1 and symbol count = nsym-1.
  - Stop: `i_stop` in RUN sets stop_pending. The current symbol completes, and the FSM leaves at the next `o_phase`=OS-1. A partial symbol is never emitted.
  - Either exit goes to DRAIN.
- DRAIN:
  - `o_tx_en`=1, `o_sym_valid`=0, `o_prbs_en`=0.
  - `o_phase` keeps cycling.
  - Lasts exactly DRAIN_SYM·OS cycles, then the FSM goes to IDLE.
  - `i_start` and `i_stop` are ignored.
- `o_done`=1 for the first IDLE cycle after DRAIN only. It is not asserted after reset.
- `i_start` is ignored while `o_busy`=1. There is no queueing.
- The symbol counter is NSYM_W bits and does not saturate. In continuous mode it wraps freely and has no effect on control.
- An asynchronous `rst` mid-burst immediately returns all outputs to 0. There is no drain and no `o_done`.

## Timing
- `i_start` is sampled at edge N. From edge N+1: `o_busy`=1, `o_tx_en`=1, `o_sym_valid`=1, `o_phase`=0.
- The first `o_prbs_en` occurs at cycle N+OS, with `o_phase`=OS-1.
- A burst of nsym symbols gives nsym·OS RUN cycles and nsym `o_prbs_en` pulses, spaced exactly OS cycles apart.
- DRAIN spans DRAIN_SYM·OS cycles. `o_phase` is continuous across the RUN→DRAIN boundary, so DRAIN starts at phase 0.
- `o_done` and `o_busy`=0 both occur at cycle N+1+(nsym+DRAIN_SYM)·OS.
- Stop latency: if `i_stop` is sampled at phase p, RUN ends after OS-1-p further cycles. If `i_stop` is sampled at phase OS-1, RUN ends on that same cycle.

## Test plan
- Fixed burst (OS=4, DRAIN_SYM=2, nsym=3, start at edge 0):
  - RUN covers cycles 1–12.
  - `o_prbs_en` pulses at 4, 8 and 12.
  - DRAIN covers cycles 13–20 with `o_sym_valid`=0.
  - `o_done` pulses and `o_busy` falls at cycle 21.
- Continuous mode (nsym=0, `i_stop` at phase 1):
  - Exactly 2 more RUN cycles follow.
  - The `o_prbs_en` count equals the number of completed symbols.
  - Then 8 DRAIN cycles, then `o_done`.
- Start ignored while busy: a second `i_start` at cycle 6 of the fixed burst leaves the timing unchanged and produces one `o_done`. `i_start` and `i_stop` together in IDLE leaves `o_busy`=0.
- Reset mid-RUN: assert `rst` at cycle 7.
  - All outputs go to 0 asynchronously and no `o_done` appears.
  - After release, a new start gives the nominal fixed-burst timing.
- nsym=1 boundary: RUN lasts OS cycles with a single `o_prbs_en` at its last cycle, then DRAIN_SYM·OS drain cycles.
- Integration with `prbs9_mod` and `tx_mod`:
  - The PRBS sequence advances once per symbol, and the `tx_mod` output holds each symbol for OS samples.
  - The `tx_mod` output returns to 0 by the end of DRAIN.

Source files
------------

// File: rtl/tx_seq_ctrl.sv
// Burst sequencer for the PRBS9 -> tx_mod chain: symbol strobes,
// sample-rate enable, symbol gating and filter drain.
module tx_seq_ctrl #(
  parameter int OS        = 4,
  parameter int NSYM_W    = 16,
  parameter int DRAIN_SYM = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [NSYM_W-1:0]     i_nsym,
  output logic                  o_prbs_en,
  output logic                  o_tx_en,
  output logic                  o_sym_valid,
  output logic [$clog2(OS)-1:0] o_phase,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int PW   = $clog2(OS);
  localparam int DLEN = DRAIN_SYM * OS;
  localparam int DW   = $clog2(DLEN + 1);

  localparam logic [PW-1:0] PH_LAST = PW'(OS - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(DLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t              state, state_n;
  logic [PW-1:0]       phase_n;
  logic [NSYM_W-1:0]   sym_cnt, sym_n;
  logic [NSYM_W-1:0]   nsym_q, nsym_n;
  logic [DW-1:0]       drain_cnt, drain_n;
  logic                stop_pend, stop_n;
  logic                done_n;
  logic                sym_last;
  logic                burst_end;

  assign sym_last  = (o_phase == PH_LAST);
  assign burst_end = (nsym_q != '0) &&
                     (sym_cnt == nsym_q - 1'b1);

  always_comb begin
    state_n = state;
    phase_n = o_phase;
    sym_n   = sym_cnt;
    nsym_n  = nsym_q;
    drain_n = drain_cnt;
    stop_n  = stop_pend;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start && !i_stop) begin
          state_n = RUN;
          nsym_n  = i_nsym;
          phase_n = '0;
          sym_n   = '0;
          drain_n = '0;
          stop_n  = 1'b0;
        end
      end
      RUN: begin
        phase_n = sym_last ? '0 : o_phase + 1'b1;
        if (i_stop) stop_n = 1'b1;
        if (sym_last) begin
          sym_n = sym_cnt + 1'b1;
          // stop sampled on the last phase still ends on this symbol
          if (burst_end || stop_pend || i_stop) begin
            state_n = DRAIN;
            drain_n = '0;
            stop_n  = 1'b0;
          end
        end
      end
      DRAIN: begin
        phase_n = sym_last ? '0 : o_phase + 1'b1;
        if (drain_cnt == D_LAST) begin
          state_n = IDLE;
          phase_n = '0;
          done_n  = 1'b1;
        end else begin
          drain_n = drain_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      o_phase     <= '0;
      sym_cnt     <= '0;
      nsym_q      <= '0;
      drain_cnt   <= '0;
      stop_pend   <= 1'b0;
      o_prbs_en   <= 1'b0;
      o_tx_en     <= 1'b0;
      o_sym_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_n;
      o_phase     <= phase_n;
      sym_cnt     <= sym_n;
      nsym_q      <= nsym_n;
      drain_cnt   <= drain_n;
      stop_pend   <= stop_n;
      o_prbs_en   <= (state_n == RUN) &&
                     (phase_n == PH_LAST);
      o_tx_en     <= (state_n != IDLE);
      o_sym_valid <= (state_n == RUN);
      o_busy      <= (state_n != IDLE);
      o_done      <= done_n;
    end
  end

endmodule

// File: tb/tb_tx_seq_ctrl.sv
// Directed bench for tx_seq_ctrl (OS=4, DRAIN_SYM=2).
// Cycle k is the cycle following clock edge k; start is sampled at edge 0.
module tb_tx_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic [15:0] i_nsym = '0;
  logic        o_prbs_en;
  logic        o_tx_en;
  logic        o_sym_valid;
  logic [1:0]  o_phase;
  logic        o_busy;
  logic        o_done;

  int checks = 0;
  int failures = 0;

  tx_seq_ctrl #(
    .OS(4),
    .NSYM_W(16),
    .DRAIN_SYM(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_stop(i_stop),
    .i_nsym(i_nsym),
    .o_prbs_en(o_prbs_en),
    .o_tx_en(o_tx_en),
    .o_sym_valid(o_sym_valid),
    .o_phase(o_phase),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  wire [6:0] obs = {o_busy, o_tx_en, o_sym_valid,
                    o_prbs_en, o_done, o_phase};

  // {busy,tx_en,sym_valid,prbs_en,done,phase} for cycle k of a burst
  // whose RUN covers cycles 1..run_len, DRAIN the next 8 cycles.
  function automatic logic [6:0] exp_vec(int k, int run_len);
    logic [1:0] ph;
    ph = 2'((k - 1) % 4);
    if (k <= run_len)
      return {1'b1, 1'b1, 1'b1, ph == 2'd3, 1'b0, ph};
    else if (k <= run_len + 8)
      return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ph};
    else if (k == run_len + 9)
      return 7'b0000100;
    else
      return 7'b0000000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== 7'd0) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=%b", obs, 7'd0);
    end
    step();
    rst = 1'b0;
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (obs !== 7'd0) begin
        failures++;
        $display("FAIL idle_after_reset k=%0d got=%b exp=%b",
                 k, obs, 7'd0);
      end
    end
  endtask

  task automatic test_fixed_burst(input int second_start);
    i_nsym = 16'd3;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_nsym = 16'd7;
    for (int k = 1; k <= 23; k++) begin
      if (k > 1) step();
      i_start = 1'b0;
      checks++;
      if (obs !== exp_vec(k, 12)) begin
        failures++;
        $display("FAIL fixed_burst ss=%0d cyc=%0d got=%b exp=%b",
                 second_start, k, obs, exp_vec(k, 12));
      end
      if (k == second_start) i_start = 1'b1;
    end
  endtask

  task automatic test_continuous_stop(input int stop_cyc,
                                      input int run_len);
    int prbs_cnt;
    prbs_cnt = 0;
    i_nsym = 16'd0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 1; k <= run_len + 10; k++) begin
      if (k > 1) step();
      i_stop = 1'b0;
      if (o_prbs_en) prbs_cnt++;
      checks++;
      if (obs !== exp_vec(k, run_len)) begin
        failures++;
        $display("FAIL cont_stop s=%0d cyc=%0d got=%b exp=%b",
                 stop_cyc, k, obs, exp_vec(k, run_len));
      end
      if (k == stop_cyc) i_stop = 1'b1;
    end
    checks++;
    if (prbs_cnt != run_len / 4) begin
      failures++;
      $display("FAIL cont_prbs_count got=%0d exp=%0d",
               prbs_cnt, run_len / 4);
    end
  endtask

  task automatic test_nsym1();
    i_nsym = 16'd1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) step();
      i_start = 1'b0;
      i_stop = 1'b0;
      checks++;
      if (obs !== exp_vec(k, 4)) begin
        failures++;
        $display("FAIL nsym1 cyc=%0d got=%b exp=%b",
                 k, obs, exp_vec(k, 4));
      end
      // start and stop during DRAIN must be ignored
      if (k == 6) i_start = 1'b1;
      if (k == 7) i_stop = 1'b1;
    end
  endtask

  task automatic test_start_stop_idle();
    i_nsym = 16'd2;
    i_start = 1'b1;
    i_stop = 1'b1;
    step();
    i_start = 1'b0;
    i_stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (obs !== 7'd0) begin
        failures++;
        $display("FAIL start_stop_idle k=%0d got=%b exp=%b",
                 k, obs, 7'd0);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    done_seen = 0;
    i_nsym = 16'd3;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 2; k <= 7; k++) step();
    checks++;
    if (obs !== exp_vec(7, 12)) begin
      failures++;
      $display("FAIL pre_reset got=%b exp=%b", obs, exp_vec(7, 12));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 7'd0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", obs, 7'd0);
    end
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (obs !== 7'd0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL post_reset_quiet active_cycles=%0d exp=0",
               done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_burst(0);
    step();
    test_fixed_burst(6);
    step();
    test_continuous_stop(6, 8);
    step();
    test_continuous_stop(8, 8);
    step();
    test_continuous_stop(13, 16);
    step();
    test_nsym1();
    step();
    test_start_stop_idle();
    test_reset_mid_run();
    test_fixed_burst(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
